// File: rtl/sram_port_pkg.sv
// Shared definitions for the async SRAM port: default widths, rwb encoding
// and the transaction FSM states.
package sram_port_pkg;

   localparam int ADDR_W_DEF = 18;
   localparam int DATA_W_DEF = 16;

   localparam logic RWB_READ  = 1'b1;
   localparam logic RWB_WRITE = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_OE    = 3'd1,
      ST_RD_CAP   = 3'd2,
      ST_WR_SETUP = 3'd3,
      ST_WR_PULSE = 3'd4,
      ST_WR_HOLD  = 3'd5
   } state_e;

endpackage

// File: rtl/sram_dq_iobuf.sv
// Tristate pad buffer for the SRAM data bus; keeps the only 'z driver in one place.
module sram_dq_iobuf #(
   parameter int W = 16
) (
   input  logic         oe_i,
   input  logic [W-1:0] out_i,
   output logic [W-1:0] in_o,
   inout  tri   [W-1:0] pad_io
);

   assign pad_io = oe_i ? out_i : {W{1'bz}};
   assign in_o   = pad_io;

endmodule

// File: rtl/sram_port.sv
// Single-requester port to an asynchronous SRAM: 3-cycle reads, 4-cycle writes.
// Handshake: a transfer happens on a BCK edge where req_valid && req_ready;
// req_ready is high only in IDLE, and the request fields are latched on that edge.
module sram_port
   import sram_port_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              BCK,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rwb,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              wr_done,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   inout  tri   [DATA_W-1:0] SRAM_DQ,
   output logic              SRAM_CE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_WE_N,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N,
   output state_e            dbg_state_o
);

   state_e            state_q, state_d;
   logic              ready_en_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              rd_valid_q;
   logic              wr_done_q;
   logic              dq_oe;
   logic [DATA_W-1:0] dq_in;
   logic              xfer;

   // ready_en_q keeps req_ready low during reset and lets it rise on the first edge after
   assign req_ready = ready_en_q && (state_q == ST_IDLE);
   assign xfer      = req_valid && req_ready;

   always_ff @(posedge BCK or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer) state_d = (req_rwb == RWB_READ) ? ST_RD_OE : ST_WR_SETUP;
         end
         ST_RD_OE:    state_d = ST_RD_CAP;
         ST_RD_CAP:   state_d = ST_IDLE;
         ST_WR_SETUP: state_d = ST_WR_PULSE;
         ST_WR_PULSE: state_d = ST_WR_HOLD;
         ST_WR_HOLD:  state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Strobes decode straight from state so reset forces WE_N high without waiting for a clock
   always_comb begin
      SRAM_CE_N = 1'b1;
      SRAM_OE_N = 1'b1;
      SRAM_WE_N = 1'b1;
      dq_oe     = 1'b0;
      case (state_q)
         ST_RD_OE, ST_RD_CAP: begin
            SRAM_CE_N = 1'b0;
            SRAM_OE_N = 1'b0;
         end
         ST_WR_SETUP, ST_WR_HOLD: begin
            SRAM_CE_N = 1'b0;
            dq_oe     = 1'b1;
         end
         ST_WR_PULSE: begin
            SRAM_CE_N = 1'b0;
            SRAM_WE_N = 1'b0;
            dq_oe     = 1'b1;
         end
         default: ;
      endcase
   end

   assign SRAM_UB_N   = SRAM_CE_N;
   assign SRAM_LB_N   = SRAM_CE_N;
   assign SRAM_ADDR   = addr_q;
   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign wr_done     = wr_done_q;
   assign dbg_state_o = state_q;

   always_ff @(posedge BCK or negedge rst_n) begin
      if (!rst_n) begin
         ready_en_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         wr_done_q  <= 1'b0;
      end else begin
         ready_en_q <= 1'b1;
         if (xfer) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         rd_valid_q <= (state_q == ST_RD_CAP);
         wr_done_q  <= (state_q == ST_WR_HOLD);
         if (state_q == ST_RD_CAP) rd_data_q <= dq_in;
      end
   end

   sram_dq_iobuf #(.W(DATA_W)) u_dq_iobuf (
      .oe_i   (dq_oe),
      .out_i  (wdata_q),
      .in_o   (dq_in),
      .pad_io (SRAM_DQ)
   );

endmodule

// File: tb/tb_sram_port.sv
// Bench for sram_port: behavioural async SRAM on the pins, reference memory and
// per-phase pin expectations derived from the read/write timing tables.
module tb_sram_port;
   import sram_port_pkg::*;

   localparam int AW = 18;
   localparam int DW = 16;

   logic          BCK = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_rwb;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   wire           req_ready;
   wire  [DW-1:0] rd_data;
   wire           rd_valid;
   wire           wr_done;
   wire  [AW-1:0] sram_addr;
   wire  [DW-1:0] sram_dq;
   wire           sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
   state_e        dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] sram_mem [logic [AW-1:0]];
   logic [DW-1:0] ref_mem  [logic [AW-1:0]];
   logic [DW-1:0] last_rd;
   logic          model_oe;
   logic [DW-1:0] model_word;
   int            mem_rev = 0;

   always #5 BCK = ~BCK;

   sram_port #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .BCK         (BCK),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_rwb     (req_rwb),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .wr_done     (wr_done),
      .SRAM_ADDR   (sram_addr),
      .SRAM_DQ     (sram_dq),
      .SRAM_CE_N   (sram_ce_n),
      .SRAM_OE_N   (sram_oe_n),
      .SRAM_WE_N   (sram_we_n),
      .SRAM_UB_N   (sram_ub_n),
      .SRAM_LB_N   (sram_lb_n),
      .dbg_state_o (dbg_state)
   );

   function automatic logic [DW-1:0] sram_rd(input logic [AW-1:0] a);
      return sram_mem.exists(a) ? sram_mem[a] : '0;
   endfunction

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : '0;
   endfunction

   // Async SRAM: drives DQ while selected for read, captures DQ mid-cycle while WE_N is low
   always @(sram_addr or sram_ce_n or sram_oe_n or sram_we_n or mem_rev) begin
      model_oe   = !sram_ce_n && !sram_oe_n && sram_we_n;
      model_word = sram_rd(sram_addr);
   end

   assign sram_dq = model_oe ? model_word : {DW{1'bz}};

   always @(negedge BCK) begin
      if (!sram_ce_n && !sram_we_n) begin
         sram_mem[sram_addr] = sram_dq;
         mem_rev++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Entered at a negedge with the port idle; returns at the negedge of the done-pulse cycle
   task automatic run_txn(input logic rwb, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit scramble);
      int            lat;
      logic          exp_we;
      logic [DW-1:0] exp_rd;
      req_valid = 1'b1;
      req_rwb   = rwb;
      req_addr  = a;
      req_wdata = d;
      chk("accept_ready", {31'd0, req_ready}, 32'd1);
      lat    = (rwb == RWB_READ) ? 3 : 4;
      exp_rd = ref_rd(a);
      if (rwb == RWB_WRITE) ref_mem[a] = d;
      @(posedge BCK);
      for (int k = 1; k < lat; k++) begin
         @(negedge BCK);
         exp_we = (rwb == RWB_WRITE && k == 2) ? 1'b0 : 1'b1;
         chk("busy_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n},
             {27'd0, 1'b0, (rwb == RWB_READ) ? 1'b0 : 1'b1, exp_we, 1'b0, 1'b0});
         chk("busy_addr", {14'd0, sram_addr}, {14'd0, a});
         chk("busy_dq", {16'd0, sram_dq}, {16'd0, (rwb == RWB_READ) ? exp_rd : d});
         chk("busy_flags", {29'd0, req_ready, rd_valid, wr_done}, 32'd0);
         if (scramble && k == 1) begin
            req_addr  = AW'($urandom);
            req_wdata = DW'($urandom);
            req_rwb   = ~rwb;
         end
      end
      @(negedge BCK);
      if (rwb == RWB_READ) last_rd = exp_rd;
      chk("done_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1f);
      chk("done_addr", {14'd0, sram_addr}, {14'd0, a});
      chk("done_flags", {29'd0, req_ready, rd_valid, wr_done}, {29'd0, 1'b1, rwb, ~rwb});
      chk("rd_data", {16'd0, rd_data}, {16'd0, last_rd});
      if (scramble && rwb == RWB_WRITE) chk("model_word", {16'd0, sram_rd(a)}, {16'd0, d});
   endtask

   initial begin
      logic [AW-1:0] wa;
      logic [DW-1:0] old_w, cur_w;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_rwb   = RWB_WRITE;
      req_addr  = '0;
      req_wdata = '0;
      last_rd   = '0;
      wa        = '0;

      repeat (2) @(negedge BCK);
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_pulses", {30'd0, rd_valid, wr_done}, 32'd0);
      chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
      chk("rst_addr", {14'd0, sram_addr}, 32'd0);
      chk("rst_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1f);
      rst_n = 1'b1;
      @(posedge BCK);
      #1 chk("ready_first_edge", {31'd0, req_ready}, 32'd1);

      for (int i = 0; i < 10; i++) begin
         @(negedge BCK);
         chk("idle_ce_n", {31'd0, sram_ce_n}, 32'd1);
         chk("idle_pulses", {30'd0, rd_valid, wr_done}, 32'd0);
      end

      run_txn(RWB_WRITE, 18'h00005, 16'h7FFF, 1'b0);
      run_txn(RWB_READ,  18'h00005, 16'h0000, 1'b0);
      req_valid = 1'b0;
      @(negedge BCK);

      run_txn(RWB_WRITE, 18'h3FFFF, 16'h8000, 1'b0);
      run_txn(RWB_READ,  18'h3FFFF, 16'h0000, 1'b0);
      req_valid = 1'b0;
      @(negedge BCK);

      run_txn(RWB_WRITE, 18'h12345, 16'hBEEF, 1'b1);
      run_txn(RWB_READ,  18'h12345, 16'h0000, 1'b1);

      // 20 back-to-back alternating transactions, req_valid never dropped
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) begin
            wa = AW'($urandom);
            run_txn(RWB_WRITE, wa, DW'($urandom), 1'b0);
         end else if ($urandom_range(0, 3) == 0) begin
            run_txn(RWB_READ, AW'($urandom), 16'h0000, 1'b0);
         end else begin
            run_txn(RWB_READ, wa, 16'h0000, 1'b0);
         end
      end
      req_valid = 1'b0;
      @(negedge BCK);

      // Reset landing in the middle of the write strobe
      old_w     = sram_rd(18'h00005);
      req_valid = 1'b1;
      req_rwb   = RWB_WRITE;
      req_addr  = 18'h00005;
      req_wdata = 16'h1234;
      @(posedge BCK);
      @(negedge BCK);
      req_valid = 1'b0;
      @(posedge BCK);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_we_n", {31'd0, sram_we_n}, 32'd1);
      chk("abort_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1f);
      chk("abort_ready", {31'd0, req_ready}, 32'd0);
      chk("abort_rd_data", {16'd0, rd_data}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge BCK);
         chk("abort_pulses", {30'd0, rd_valid, wr_done}, 32'd0);
      end
      cur_w = sram_rd(18'h00005);
      chk("abort_mem_whole", {31'd0, (cur_w === old_w) || (cur_w === 16'h1234)}, 32'd1);
      ref_mem[18'h00005] = cur_w;
      last_rd = '0;
      rst_n   = 1'b1;
      @(posedge BCK);
      #1 chk("ready_after_abort", {31'd0, req_ready}, 32'd1);
      @(negedge BCK);
      chk("post_abort_pulses", {30'd0, rd_valid, wr_done}, 32'd0);
      run_txn(RWB_READ, 18'h00005, 16'h0000, 1'b0);
      run_txn(RWB_WRITE, 18'h00006, 16'h0F0F, 1'b0);
      req_valid = 1'b0;
      @(negedge BCK);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete within the time limit");
      $fatal(1, "timeout");
   end

endmodule
